// File: rtl/trigger_link_sequencer_pkg.sv
// Shared state encoding, default cycle counts and timer sizing for the trigger TX link sequencer.
package trigger_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        GTX_RST   = 3'd3,
        WAIT_DONE = 3'd4,
        TEST_PAT  = 3'd5,
        READY     = 3'd6,
        FAULT     = 3'd7
    } tl_state_e;

    localparam int unsigned DEF_NLINKS         = 4;
    localparam int unsigned DEF_PLLRST_CYCLES  = 16;
    localparam int unsigned DEF_GTXRST_CYCLES  = 32;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 4096;
    localparam int unsigned DEF_TESTPAT_CYCLES = 1024;
    localparam int unsigned DEF_RETRY_MAX      = 15;

    // Enough bits to count up to the largest cycle parameter minus one.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/trigger_link_sequencer_sync.sv
// NLINKS-wide two-flop synchroniser for the asynchronous GTX status bits.
module link_status_sync #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/trigger_link_sequencer.sv
// Power-up / recovery sequencer for the GTX trigger TX links (PLL reset, GTX reset, test pattern).
// Optional lock-loss counter output loss_cnt enabled by defining TRIG_LINK_LOSS_CNT_EN.
module trigger_link_sequencer
    import trigger_link_pkg::*;
#(
    parameter int unsigned NLINKS         = DEF_NLINKS,
    parameter int unsigned PLLRST_CYCLES  = DEF_PLLRST_CYCLES,
    parameter int unsigned GTXRST_CYCLES  = DEF_GTXRST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned TESTPAT_CYCLES = DEF_TESTPAT_CYCLES,
    parameter int unsigned RETRY_MAX      = DEF_RETRY_MAX
) (
    input  logic              clk_40,
    input  logic              reset,
    input  logic              enable,
    input  logic              force_reset,
    input  logic [NLINKS-1:0] link_mask,
    input  logic [NLINKS-1:0] tx_pll_locked,
    input  logic [NLINKS-1:0] tx_resetdone,
    output logic              txpll_rst,
    output logic              gtx_reset,
    output logic              ena_test_pat,
    output logic              links_ready,
    output logic              fault,
    output logic [2:0]        state,
    output logic [3:0]        retry_cnt
`ifdef TRIG_LINK_LOSS_CNT_EN
    ,
    output logic [15:0]       loss_cnt
`endif
);

    localparam int unsigned TW = timer_width(PLLRST_CYCLES, GTXRST_CYCLES, LOCK_TIMEOUT, TESTPAT_CYCLES);
    localparam logic [TW-1:0] PLL_LAST = TW'(PLLRST_CYCLES - 1);
    localparam logic [TW-1:0] GTX_LAST = TW'(GTXRST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TP_LAST  = (TESTPAT_CYCLES == 0) ? '0 : TW'(TESTPAT_CYCLES - 1);

    logic [NLINKS-1:0] sync_locked;
    logic [NLINKS-1:0] sync_done;
    logic              lock_ok;
    logic              done_ok;

    link_status_sync #(.W(NLINKS)) u_sync_locked (
        .clk      (clk_40),
        .rst_n    (reset),
        .async_in (tx_pll_locked),
        .sync_out (sync_locked)
    );

    link_status_sync #(.W(NLINKS)) u_sync_done (
        .clk      (clk_40),
        .rst_n    (reset),
        .async_in (tx_resetdone),
        .sync_out (sync_done)
    );

    // Mask is applied after synchronisation so a mask change acts on the very next cycle.
    assign lock_ok = &(sync_locked | link_mask);
    assign done_ok = &(sync_done | link_mask);

    tl_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;
    logic          restart;
    logic          timeout;
    logic          txpll_rst_q, txpll_rst_d;
    logic          gtx_reset_q, gtx_reset_d;
    logic          ena_test_pat_q, ena_test_pat_d;
    logic          links_ready_q, links_ready_d;
    logic          fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        restart = 1'b0;
        timeout = (timer_q == TO_LAST);

        if (!enable) begin
            state_d = IDLE;
            retry_d = '0;
        end else if (force_reset) begin
            state_d = PLL_RST;
            retry_d = '0;
            restart = 1'b1;
        end else begin
            case (state_q)
                IDLE:      state_d = PLL_RST;
                PLL_RST:   if (timer_q == PLL_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (timeout) begin
                        if (retry_q == 4'(RETRY_MAX)) begin
                            state_d = FAULT;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = PLL_RST;
                        end
                    end else if (lock_ok) begin
                        state_d = GTX_RST;
                    end
                end
                GTX_RST:   if (timer_q == GTX_LAST) state_d = WAIT_DONE;
                WAIT_DONE: begin
                    if (timeout) begin
                        if (retry_q == 4'(RETRY_MAX)) begin
                            state_d = FAULT;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = PLL_RST;
                        end
                    end else if (done_ok && lock_ok) begin
                        if (TESTPAT_CYCLES == 0) begin
                            state_d = READY;
                            retry_d = '0;
                        end else begin
                            state_d = TEST_PAT;
                        end
                    end
                end
                TEST_PAT: begin
                    if (timer_q == TP_LAST) begin
                        state_d = READY;
                        retry_d = '0;
                    end
                end
                READY:     if (!lock_ok) state_d = PLL_RST;
                FAULT:     state_d = FAULT;
                default:   state_d = IDLE;
            endcase
        end

        // Timer saturates rather than wrapping in states with no exit count.
        if ((state_d != state_q) || restart) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        txpll_rst_d    = state_d inside {IDLE, PLL_RST, FAULT};
        gtx_reset_d    = state_d inside {IDLE, PLL_RST, WAIT_LOCK, GTX_RST, FAULT};
        ena_test_pat_d = (state_d == TEST_PAT);
        links_ready_d  = (state_d == READY);
        fault_d        = (state_d == FAULT);
    end

    always_ff @(posedge clk_40 or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            retry_q        <= '0;
            txpll_rst_q    <= 1'b1;
            gtx_reset_q    <= 1'b1;
            ena_test_pat_q <= 1'b0;
            links_ready_q  <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            txpll_rst_q    <= txpll_rst_d;
            gtx_reset_q    <= gtx_reset_d;
            ena_test_pat_q <= ena_test_pat_d;
            links_ready_q  <= links_ready_d;
            fault_q        <= fault_d;
        end
    end

    assign txpll_rst    = txpll_rst_q;
    assign gtx_reset    = gtx_reset_q;
    assign ena_test_pat = ena_test_pat_q;
    assign links_ready  = links_ready_q;
    assign fault        = fault_q;
    assign state        = state_q;
    assign retry_cnt    = retry_q;

`ifdef TRIG_LINK_LOSS_CNT_EN
    logic [15:0] loss_q, loss_d;
    logic        lock_loss;

    assign lock_loss = enable && !force_reset && (state_q == READY) && !lock_ok;

    always_comb begin
        loss_d = loss_q;
        if (!enable) begin
            loss_d = '0;
        end else if (lock_loss && (loss_q != '1)) begin
            loss_d = loss_q + 16'd1;
        end
    end

    always_ff @(posedge clk_40 or negedge reset) begin
        if (!reset) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule
